fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Small instruction FIFO between the fetch stage (PC register + IM) and the decode stage of the P5 pipelined MIPS CPU.
- Captures {PC, instruction} pairs from fetch. Presents the oldest pair to decode.
- Drives the fetch enable through in_ready. Drops all in-flight entries on a redirect flush.
- Decouples fetch from decode stalls without a combinational path from decode stall to the PC enable.

Parameters:
- DEPTH, 2, number of entries; power of 2, at least 2.
- PTR_W, $clog2(DEPTH), pointer width. Derived; not overridden.
- RESET_PC, 32'h0000_3000, PC value reported on out_pc when the queue is empty.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears queue.
- in_valid  input  1  fetch presents a valid {in_pc, in_instr} this cycle.
- in_pc  input  32  PC of fetched instruction.
- in_instr  input  32  instruction word from IM.
- in_ready  output  1  queue can accept; connects to fetch PC enable.
- out_valid  output  1  head entry valid.
- out_pc  output  32  PC of head entry.
- out_instr  output  32  instruction of head entry.
- out_ready  input  1  decode consumes head this cycle (decode not stalled).
- flush  input  1  discard all entries (branch/jump redirect).
- count  output  PTR_W+1  current occupancy 0..DEPTH.

Behaviour:
- State:
  - storage arrays pc_q[DEPTH] and instr_q[DEPTH];
  - rd_ptr and wr_ptr, each PTR_W bits, wrapping modulo DEPTH;
  - cnt, PTR_W+1 bits.
- Reset, synchronous and highest priority:
  - rd_ptr=0, wr_ptr=0, cnt=0.
  - Outputs after reset: out_valid=0, out_instr=32'h0000_0000 (nop), out_pc=RESET_PC, in_ready=1, count=0.
  - Storage contents need not be cleared.
- in_ready = (cnt != DEPTH). It is purely a function of registered state, with no path from out_ready or in_valid.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready.
- out_valid = (cnt != 0).
- Head data:
  - When out_valid=1: out_pc=pc_q[rd_ptr] and out_instr=instr_q[rd_ptr].
  - When out_valid=0: out_instr=0 (nop bubble) and out_pc=RESET_PC.
- Zero-latency read: an entry written at edge N is visible on out_* in the cycle after edge N.
- There is no same-cycle bypass from in_* to out_*.
- Update at posedge when reset=0:
  - flush=1: rd_ptr=0, wr_ptr=0, cnt=0. Same-cycle push is dropped. A same-cycle pop is treated as consumed: decode latched the head, and redirect logic accounts for the delay slot.
  - Otherwise, push only: write pc_q/instr_q[wr_ptr], wr_ptr+=1, cnt+=1.
  - Otherwise, pop only: rd_ptr+=1, cnt-=1.
  - Otherwise, push and pop together: both pointers advance and cnt is unchanged. This is legal at any cnt in 1..DEPTH-1. At cnt=DEPTH, push is impossible because in_ready=0.
  - Otherwise, no event: hold.
- Full boundary:
  - When cnt=DEPTH, in_ready=0 and fetch holds its PC.
  - A pop while full raises in_ready in the next cycle, not the same cycle.
- Empty boundary: when cnt=0, a pop cannot occur, and out_ready is ignored.
- Pointer wrap: DEPTH-1 increments to 0. cnt never exceeds DEPTH or underflows below 0. Assert this in simulation.
- Delay slot: the queue has no knowledge of branches. The redirect controller asserts flush only after the delay-slot instruction has popped.
- in_valid is expected to be tied to ~reset. Entries carry no other status.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h0000_0000;
  - RESET_PC = 32'h0000_3000;
  - an if_entry struct {pc[31:0], instr[31:0]} reused by the IF/ID path.
- Single module, with no sub-module. Pointer/count logic and storage are small enough to stay flat.
- A generic sync_fifo is not introduced, because the nop/RESET_PC empty output is stage-specific.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, out_instr=0, out_pc=0x3000, in_ready=1, count=0. Expect no write.
- Fill: out_ready=0, push PC 0x3000/instr 0x3C011234 then PC 0x3004/instr 0x34210001 -> count=2, in_ready=0. A third in_valid is ignored. out_pc=0x3000, out_instr=0x3C011234.
- Drain with wrap: from full, out_ready=1 for 2 cycles -> out_pc 0x3000 then 0x3004, count 1 then 0. in_ready=1 the cycle after the first pop. Push 0x3008 next -> written at index 0 and presented correctly.
- Simultaneous push/pop: with count=1 (head 0x3000), in_valid=1 (0x3004) and out_ready=1 -> count stays 1, next head 0x3004. Stream 8 instructions continuously and check in-order output with no bubbles.
- Flush: count=2, flush=1 with in_valid=1 (0x3010) and out_ready=1 -> next cycle count=0, out_valid=0, out_instr=0. 0x3010 is not stored. The following push of 0x4000 appears as head next cycle.
- Reset mid-operation: count=2, then assert reset with flush=0 and in_valid=1 -> next cycle count=0, out_pc=0x3000, in_ready=1. Old entries are never presented.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared IF/ID definitions for the P5 pipeline front end.
//   NOP_INSTR : instruction word presented as a bubble
//   RESET_PC  : first fetch address, also the PC reported for bubbles
//   if_entry  : {pc, instr} pair carried from fetch to decode
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
//   in_valid/in_pc/in_instr/in_ready    : fetch side (in_ready drives PC enable)
//   out_valid/out_pc/out_instr/out_ready: decode side
//   flush                               : redirect, drops all queued entries
//   count                               : occupancy 0..DEPTH
// slave is the queue itself; master is the surrounding pipeline.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              in_valid;
  logic [31:0]       in_pc;
  logic [31:0]       in_instr;
  logic              in_ready;
  logic              out_valid;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic              out_ready;
  logic              flush;
  logic [PTR_W:0]    count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction FIFO between fetch and decode. Holds {PC, instruction}
// pairs, presents the oldest to decode, and drops everything on flush.
// in_ready depends only on registered occupancy, so a decode stall never
// reaches the PC enable combinationally. When empty the head reads as a
// nop at RESET_PC.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_queue_if.slave (fetch in, decode out, flush, count)
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = fetch_queue_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  if_entry          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   cnt;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic             not_full;

  assign not_empty = (cnt != '0);
  assign not_full  = (cnt != FULL);

  assign push = bus.in_valid & not_full & ~bus.flush;
  assign pop  = not_empty & bus.out_ready;

  assign bus.in_ready  = not_full;
  assign bus.out_valid = not_empty;
  assign bus.out_pc    = not_empty ? mem[rd_ptr].pc    : RESET_PC;
  assign bus.out_instr = not_empty ? mem[rd_ptr].instr : NOP_INSTR;
  assign bus.count     = cnt;

  // Storage is not reset; the reset term only keeps a tied-high in_valid
  // from writing during reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
  end

  // A pop coinciding with flush needs no special handling: decode has
  // already latched the head, and flush clears everything anyway.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (cnt <= FULL) else $error("fetch_queue: occupancy above DEPTH");
      assert (!(push && cnt == FULL)) else $error("fetch_queue: push while full");
      assert (!(pop && cnt == '0)) else $error("fetch_queue: pop while empty");
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(2)) bus ();

  fetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  if_entry sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every accepted head is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pop: got pc %h expected no entry", bus.out_pc);
      end else begin
        if_entry e;
        e = sb.pop_front();
        chk("pop_pc", bus.out_pc, e.pc);
        chk("pop_instr", bus.out_instr, e.instr);
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a push that must be accepted; the expected entry goes to the scoreboard.
  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic ordy);
    drive(1'b1, pc, instr, ordy, 1'b0);
    sb.push_back('{pc: pc, instr: instr});
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with fetch trying to write
    reset = 1'b1;
    drive(1'b1, 32'hDEAD_0000, 32'hBAD0_BAD0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h3000);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("rst_no_write", 32'(bus.out_valid), 32'd0);

    // Fill
    push_exp(32'h3000, 32'h3C01_1234, 1'b0);
    chk("fill1_count", 32'(bus.count), 32'd1);
    chk("fill1_head_visible", bus.out_pc, 32'h3000);
    push_exp(32'h3004, 32'h3421_0001, 1'b0);
    chk("full_count", 32'(bus.count), 32'd2);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_pc", bus.out_pc, 32'h3000);
    chk("full_out_instr", bus.out_instr, 32'h3C01_1234);
    drive(1'b1, 32'h300C, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    chk("full_ignore_count", 32'(bus.count), 32'd2);
    chk("full_ignore_head", bus.out_pc, 32'h3000);

    // Drain with wrap
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("drain1_count", 32'(bus.count), 32'd1);
    chk("drain1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("drain1_out_pc", bus.out_pc, 32'h3004);
    step();
    chk("drain2_count", 32'(bus.count), 32'd0);
    chk("drain2_out_pc", bus.out_pc, 32'h3000);
    chk("drain2_out_instr", bus.out_instr, 32'h0);
    push_exp(32'h3008, 32'h2008_0005, 1'b0);
    chk("wrap_out_pc", bus.out_pc, 32'h3008);
    chk("wrap_out_instr", bus.out_instr, 32'h2008_0005);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("wrap_drained", 32'(bus.count), 32'd0);

    // Simultaneous push/pop and streaming
    push_exp(32'h3000, 32'h1111_0000, 1'b0);
    push_exp(32'h3004, 32'h1111_0001, 1'b1);
    chk("pp_count", 32'(bus.count), 32'd1);
    chk("pp_head", bus.out_pc, 32'h3004);
    for (int i = 0; i < 8; i++) begin
      push_exp(32'h3008 + 32'(4 * i), 32'h2222_0000 + 32'(i), 1'b1);
      chk("stream_count", 32'(bus.count), 32'd1);
      chk("stream_no_bubble", 32'(bus.out_valid), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("stream_drained", 32'(bus.count), 32'd0);

    // Flush at full with push and pop attempted
    push_exp(32'h3100, 32'h3333_0000, 1'b0);
    push_exp(32'h3104, 32'h3333_0001, 1'b0);
    drive(1'b1, 32'h3010, 32'h4444_0000, 1'b1, 1'b1);
    step();
    sb.delete();
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_out_instr", bus.out_instr, 32'h0);
    push_exp(32'h4000, 32'h5555_0000, 1'b0);
    chk("post_flush_head", bus.out_pc, 32'h4000);
    chk("post_flush_count", 32'(bus.count), 32'd1);
    // Flush at count=1 with room: the push must still be dropped
    drive(1'b1, 32'h3010, 32'h4444_0001, 1'b0, 1'b1);
    step();
    sb.delete();
    chk("flush_drop_push", 32'(bus.count), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("flush_drop_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation
    push_exp(32'h5000, 32'h6666_0000, 1'b0);
    push_exp(32'h5004, 32'h6666_0001, 1'b0);
    reset = 1'b1;
    drive(1'b1, 32'h5008, 32'h6666_0002, 1'b0, 1'b0);
    step();
    sb.delete();
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_out_pc", bus.out_pc, 32'h3000);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("mid_rst_no_old", 32'(bus.out_valid), 32'd0);
    push_exp(32'h6000, 32'h7777_0000, 1'b0);
    chk("mid_rst_new_head", bus.out_pc, 32'h6000);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
